cpu_wb_arbiter: RTL and testbench

// - Writeback stage directly upstream of cpu_gregs.
// - Merges ALU and LSU results onto the single register-file write port (rd_wen/rd_idx/rd_dat).
// - Keeps a pending-write scoreboard that decode reads for RAW/WAW interlock.
// - Its registered rd_* outputs double as the operand bypass source, because cpu_gregs reads return pre-write data on the write edge.

---
 rtl/cpu_wb_arbiter_pkg.sv | 8 +
 rtl/cpu_wb_fifo.sv | 55 +++++
 rtl/cpu_wb_arbiter.sv | 89 ++++++++
 tb/tb_cpu_wb_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cpu_wb_arbiter_pkg.sv
// cpu_wb_arbiter_pkg: shared core widths and writeback source encoding
package cpu_wb_arbiter_pkg;
   localparam int CPU_XLEN          = 32;
   localparam int CPU_GREG_COUNT    = 32;
   localparam int CPU_GREGIDX_WIDTH = 5;
   localparam int CPU_WB_Q_DEPTH    = 2;
   typedef enum logic [1:0] {SRC_NONE, SRC_LSU, SRC_QUEUE, SRC_ALU} wb_src_e;
endpackage

// File: rtl/cpu_wb_fifo.sv
// cpu_wb_fifo: count-based circular buffer holding deferred ALU {idx,dat} results
module cpu_wb_fifo
   import cpu_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = CPU_WB_Q_DEPTH,
   parameter int XLEN  = CPU_XLEN,
   parameter int IDX_W = CPU_GREGIDX_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [XLEN-1:0]  dat_i,
   output logic [IDX_W-1:0] idx_o,
   output logic [XLEN-1:0]  dat_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [IDX_W-1:0] idx_mem [DEPTH];
   logic [XLEN-1:0]  dat_mem [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // Pointer and occupancy update; simultaneous push and pop keep the count
   always_comb begin
      wr_d  = push_i ? wr_q + AW'(1) : wr_q;
      rd_d  = pop_i ? rd_q + AW'(1) : rd_q;
      cnt_d = (push_i && !pop_i) ? cnt_q + CW'(1) : (pop_i && !push_i) ? cnt_q - CW'(1) : cnt_q;
   end
   // Control state register; reset discards all queued entries
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   // Entry storage needs no reset since occupancy gates its use
   always_ff @(posedge clk) begin
      if (push_i) begin
         idx_mem[wr_q] <= idx_i;
         dat_mem[wr_q] <= dat_i;
      end
   end
   assign idx_o   = idx_mem[rd_q];
   assign dat_o   = dat_mem[rd_q];
   assign full_o  = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
endmodule

// File: rtl/cpu_wb_arbiter.sv
// cpu_wb_arbiter: merges LSU and ALU results onto the register-file write port and tracks pending writes
module cpu_wb_arbiter
   import cpu_wb_arbiter_pkg::*;
#(
   parameter int XLEN        = CPU_XLEN,
   parameter int GREG_COUNT  = CPU_GREG_COUNT,
   parameter int IDX_W       = CPU_GREGIDX_WIDTH,
   parameter int ALU_Q_DEPTH = CPU_WB_Q_DEPTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             alu_valid,
   output logic             alu_ready,
   input  logic [IDX_W-1:0] alu_rd_idx,
   input  logic [XLEN-1:0]  alu_dat,
   input  logic             lsu_valid,
   input  logic [IDX_W-1:0] lsu_rd_idx,
   input  logic [XLEN-1:0]  lsu_dat,
   input  logic             iss_valid,
   input  logic [IDX_W-1:0] iss_rd_idx,
   input  logic [IDX_W-1:0] dec_rs1_idx,
   input  logic [IDX_W-1:0] dec_rs2_idx,
   input  logic [IDX_W-1:0] dec_rd_idx,
   output logic             raw_hazard,
   output logic             rd_wen,
   output logic [IDX_W-1:0] rd_idx,
   output logic [XLEN-1:0]  rd_dat
);
   wb_src_e          src;
   logic             alu_acc, q_push, q_pop, q_full, q_empty, sel_valid;
   logic [IDX_W-1:0] q_idx, sel_idx;
   logic [XLEN-1:0]  q_dat, sel_dat;
   logic             rd_wen_q, rd_wen_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic [XLEN-1:0]  rd_dat_q, rd_dat_d;
   logic [GREG_COUNT-1:0] pend_q, pend_d;
   cpu_wb_fifo #(.DEPTH(ALU_Q_DEPTH), .XLEN(XLEN), .IDX_W(IDX_W)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (q_push),
      .pop_i   (q_pop),
      .idx_i   (alu_rd_idx),
      .dat_i   (alu_dat),
      .idx_o   (q_idx),
      .dat_o   (q_dat),
      .full_o  (q_full),
      .empty_o (q_empty)
   );
   assign alu_ready = !q_full;
   assign alu_acc   = alu_valid && alu_ready;
   // Pick LSU first, then the oldest queued ALU result, else bypass the queue with the live ALU result
   always_comb begin
      src       = lsu_valid ? SRC_LSU : !q_empty ? SRC_QUEUE : alu_acc ? SRC_ALU : SRC_NONE;
      sel_valid = src != SRC_NONE;
      sel_idx   = src == SRC_LSU ? lsu_rd_idx : src == SRC_QUEUE ? q_idx : alu_rd_idx;
      sel_dat   = src == SRC_LSU ? lsu_dat : src == SRC_QUEUE ? q_dat : alu_dat;
      q_push    = alu_acc && src != SRC_ALU;
      q_pop     = src == SRC_QUEUE;
      rd_wen_d  = sel_valid && sel_idx != '0;
      rd_idx_d  = sel_valid ? sel_idx : rd_idx_q;
      rd_dat_d  = sel_valid ? sel_dat : rd_dat_q;
   end
   // Scoreboard next state: issue sets, writeback clears, set wins on collision, x0 never pending
   always_comb begin
      pend_d = '0;
      for (int i = 1; i < GREG_COUNT; i++)
         pend_d[i] = (iss_valid && iss_rd_idx == IDX_W'(i)) || (pend_q[i] && !(sel_valid && sel_idx == IDX_W'(i)));
   end
   // Writeback port and scoreboard registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_wen_q <= 1'b0;
         rd_idx_q <= '0;
         rd_dat_q <= '0;
         pend_q   <= '0;
      end else begin
         rd_wen_q <= rd_wen_d;
         rd_idx_q <= rd_idx_d;
         rd_dat_q <= rd_dat_d;
         pend_q   <= pend_d;
      end
   end
   assign rd_wen     = rd_wen_q;
   assign rd_idx     = rd_idx_q;
   assign rd_dat     = rd_dat_q;
   assign raw_hazard = pend_q[dec_rs1_idx] | pend_q[dec_rs2_idx] | pend_q[dec_rd_idx];
   a_no_dual_dest: assert property (@(posedge clk) disable iff (!reset_n)
      !(lsu_valid && alu_acc && lsu_rd_idx == alu_rd_idx && lsu_rd_idx != '0));
endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// tb_cpu_wb_arbiter: directed vectors against hand-computed writeback and hazard results
module tb_cpu_wb_arbiter;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        alu_valid = 1'b0, alu_ready;
   logic [4:0]  alu_rd_idx = '0;
   logic [31:0] alu_dat = '0;
   logic        lsu_valid = 1'b0;
   logic [4:0]  lsu_rd_idx = '0;
   logic [31:0] lsu_dat = '0;
   logic        iss_valid = 1'b0;
   logic [4:0]  iss_rd_idx = '0;
   logic [4:0]  dec_rs1_idx = '0, dec_rs2_idx = '0, dec_rd_idx = '0;
   logic        raw_hazard, rd_wen;
   logic [4:0]  rd_idx;
   logic [31:0] rd_dat;
   int          vectors = 0, errs = 0;
   logic [7:0]  rdy_exp;
   logic [4:0]  aidx;
   logic        rdy;

   cpu_wb_arbiter dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_rd_idx  (alu_rd_idx),
      .alu_dat     (alu_dat),
      .lsu_valid   (lsu_valid),
      .lsu_rd_idx  (lsu_rd_idx),
      .lsu_dat     (lsu_dat),
      .iss_valid   (iss_valid),
      .iss_rd_idx  (iss_rd_idx),
      .dec_rs1_idx (dec_rs1_idx),
      .dec_rs2_idx (dec_rs2_idx),
      .dec_rd_idx  (dec_rd_idx),
      .raw_hazard  (raw_hazard),
      .rd_wen      (rd_wen),
      .rd_idx      (rd_idx),
      .rd_dat      (rd_dat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      iss_valid = 1'b0;
   endtask

   initial begin
      // reset held with live traffic
      lsu_valid = 1'b1; lsu_rd_idx = 5'd3; lsu_dat = 32'h1;
      alu_valid = 1'b1; alu_rd_idx = 5'd4; alu_dat = 32'h2;
      iss_valid = 1'b1; iss_rd_idx = 5'd6; dec_rs1_idx = 5'd6;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("rst_wen", rd_wen, 0);
         chk("rst_rdy", alu_ready, 1);
         chk("rst_haz", raw_hazard, 0);
      end
      idle();
      dec_rs1_idx = 5'd0;
      reset_n = 1'b1;
      cyc();
      chk("post_rst_wen", rd_wen, 0);
      // single ALU result bypasses empty queue
      alu_valid = 1'b1; alu_rd_idx = 5'd5; alu_dat = 32'h1234;
      cyc();
      idle();
      chk("alu_wen", rd_wen, 1);
      chk("alu_idx", rd_idx, 5);
      chk("alu_dat", rd_dat, 32'h1234);
      cyc();
      chk("alu_wen_once", rd_wen, 0);
      // LSU and ALU together: LSU first, ALU next cycle
      lsu_valid = 1'b1; lsu_rd_idx = 5'd3; lsu_dat = 32'hAAAA;
      alu_valid = 1'b1; alu_rd_idx = 5'd4; alu_dat = 32'hBBBB;
      cyc();
      idle();
      chk("mix_idx0", rd_idx, 3);
      chk("mix_dat0", rd_dat, 32'hAAAA);
      chk("mix_rdy", alu_ready, 1);
      cyc();
      chk("mix_wen1", rd_wen, 1);
      chk("mix_idx1", rd_idx, 4);
      chk("mix_dat1", rd_dat, 32'hBBBB);
      cyc();
      chk("mix_idle", rd_wen, 0);
      // LSU stream backs up ALU results into a full queue
      rdy_exp = 8'b0110_0011;
      aidx = 5'd8;
      for (int k = 0; k < 8; k++) begin
         lsu_valid = k < 4; lsu_rd_idx = 5'(20 + k); lsu_dat = 32'hC000_0000 + k;
         alu_valid = aidx <= 5'd11; alu_rd_idx = aidx; alu_dat = 32'hA000_0000 + 32'(aidx);
         #1;
         if (alu_valid) chk("q_rdy", alu_ready, 32'(rdy_exp[k]));
         rdy = alu_ready;
         cyc();
         if (alu_valid && rdy) aidx = aidx + 5'd1;
         chk("q_wen", rd_wen, 1);
         chk("q_idx", rd_idx, k < 4 ? 20 + k : 4 + k);
         chk("q_dat", rd_dat, k < 4 ? 32'hC000_0000 + k : 32'hA000_0000 + 4 + k);
      end
      idle();
      cyc();
      chk("q_drained", rd_wen, 0);
      chk("q_rdy_end", alu_ready, 1);
      // scoreboard: issue, hold, clear with same-cycle re-issue, then clear
      iss_valid = 1'b1; iss_rd_idx = 5'd7;
      cyc();
      iss_valid = 1'b0; dec_rs1_idx = 5'd7;
      #1;
      chk("haz_set", raw_hazard, 1);
      dec_rs1_idx = 5'd0; dec_rs2_idx = 5'd7;
      #1;
      chk("haz_rs2", raw_hazard, 1);
      dec_rs2_idx = 5'd0; dec_rd_idx = 5'd7;
      cyc();
      chk("haz_hold", raw_hazard, 1);
      alu_valid = 1'b1; alu_rd_idx = 5'd7; alu_dat = 32'h77;
      iss_valid = 1'b1; iss_rd_idx = 5'd7;
      cyc();
      idle();
      chk("haz_wr_idx", rd_idx, 7);
      chk("haz_reissue", raw_hazard, 1);
      alu_valid = 1'b1; alu_rd_idx = 5'd7; alu_dat = 32'h78;
      cyc();
      idle();
      chk("haz_clr", raw_hazard, 0);
      dec_rd_idx = 5'd0;
      // x0 writes suppressed and never pending
      alu_valid = 1'b1; alu_rd_idx = 5'd0; alu_dat = 32'hFFFF;
      iss_valid = 1'b1; iss_rd_idx = 5'd0;
      cyc();
      idle();
      chk("x0_wen", rd_wen, 0);
      chk("x0_haz", raw_hazard, 0);
      cyc();
      chk("x0_wen2", rd_wen, 0);
      // reset with two entries queued
      for (int k = 0; k < 2; k++) begin
         lsu_valid = 1'b1; lsu_rd_idx = 5'(24 + k); lsu_dat = 32'h5;
         alu_valid = 1'b1; alu_rd_idx = 5'(12 + k); alu_dat = 32'h6;
         cyc();
      end
      idle();
      chk("fill_rdy", alu_ready, 0);
      reset_n = 1'b0;
      cyc();
      chk("mid_rst_wen", rd_wen, 0);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("after_rst_wen", rd_wen, 0);
      end
      chk("after_rst_rdy", alu_ready, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
